smoldvi_lane_sequencer: RTL and testbench
=========================================

SMOLDVI_LANE_SEQUENCER -- requirements
Module: smoldvi_lane_sequencer

Interface
REQ-001 The module SHALL have parameter WARMUP_PERIODS, default 16: pixel periods of clock-only output before data lanes enable; legal range 1..255.
REQ-002 The module SHALL have parameter COOLDOWN_PERIODS, default 8: pixel periods of clock-only output after data lanes disable; legal range 1..255.
REQ-003 The module SHALL have port clk_x5  input  1  half-rate bit clock (5x pixel clock).
REQ-004 The module SHALL have port rst_n_x5  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port en_req  input  1  output-enable request, asynchronous to clk_x5.
REQ-006 The module SHALL have port hpd  input  1  sink hot-plug detect, asynchronous to clk_x5.
REQ-007 The module SHALL have port phase  output  3  serialiser phase, 0..4.
REQ-008 The module SHALL have port clk_lane_en  output  1  enables the pseudodifferential clock-lane driver.
REQ-009 The module SHALL have port data_lane_en  output  1  enables the three TMDS data serialisers.
REQ-010 The module SHALL have port ser_load  output  1  one-cycle strobe loading the next 10-bit symbol into the serialisers.
REQ-011 The module SHALL have port state  output  2  current state encoding (OFF=0, WARMUP=1, RUN=2, DRAIN=3).
REQ-012 The module SHALL have port hpd_lost  output  1  sticky flag: hpd dropped while in RUN.

Function
REQ-013 en_req and hpd SHALL each pass through a 2-flop synchroniser; en_s and hpd_s denote the synchronised values; go = en_s AND hpd_s.
REQ-014 phase SHALL be 0 on the first clk_x5 edge after reset release, increment by 1 each cycle, and wrap 4->0.
REQ-015 tick SHALL be true in every cycle where phase==4; one pixel period is five cycles.
REQ-016 State changes SHALL occur only on the clock edge ending a tick cycle, so every new state begins with phase==0.
REQ-017 In OFF: if go on tick -> WARMUP and clear the period counter; otherwise remain.
REQ-018 In WARMUP: each tick with go SHALL increment the period counter; on the tick where counter==WARMUP_PERIODS-1 -> RUN; on a tick with go low -> OFF.
REQ-019 In RUN: on a tick with go low -> DRAIN and clear the period counter; otherwise remain.
REQ-020 In DRAIN: each tick SHALL increment the period counter; on the tick where counter==COOLDOWN_PERIODS-1 -> OFF; go is ignored until OFF is reached.
REQ-021 clk_lane_en SHALL be 1 exactly when state is WARMUP, RUN or DRAIN.
REQ-022 data_lane_en SHALL be 1 exactly when state is RUN.
REQ-023 ser_load SHALL be 1 exactly in cycles where state==RUN and phase==0; first strobe is the first RUN cycle; strobes are spaced exactly 5 cycles apart.
REQ-024 All outputs SHALL be driven directly from flops (glitch-free); the period counter is 8 bits and SHALL never wrap.
REQ-025 hpd_lost SHALL set on any cycle with state==RUN and hpd_s==0, and clear only when en_s==0.
REQ-026 Simultaneous tick with WARMUP completion and go low SHALL take the go-low path (-> OFF).

Reset
REQ-027 While rst_n_x5==0 (asserted at any time, including mid-RUN): phase=0, state=OFF, period counter=0, synchronisers=0, clk_lane_en=0, data_lane_en=0, ser_load=0, hpd_lost=0, effective immediately without a clock edge.

Verification
REQ-028 en_req=hpd=1 from reset release (cycle 0) -> WARMUP from cycle 5, RUN and first ser_load at cycle 85, next ser_load at 90.
REQ-029 In RUN, drop en_req -> data_lane_en falls at a phase-0 boundary; clk_lane_en stays high exactly 40 cycles (8 periods), then state=OFF.
REQ-030 Drop hpd during WARMUP period 10 -> return to OFF at the next tick; data_lane_en never asserts.
REQ-031 Drop hpd in RUN, then restore it -> hpd_lost=1 persists through DRAIN and OFF; clears 2-3 cycles after en_req goes low.
REQ-032 Assert rst_n_x5=0 mid-RUN at phase 2 -> all outputs are 0 in the same cycle; after release, the REQ-028 timing repeats.
REQ-033 Re-assert en_req during DRAIN -> DRAIN completes its full 8 periods, then OFF -> WARMUP at the following tick.

Source files
------------

// File: rtl/smoldvi_lane_sequencer.sv
// smoldvi_lane_sequencer
// Output-enable sequencer for a small DVI transmitter running on the 5x bit clock.
// It free-runs a 0..4 serialiser phase and brings lanes up and down in order:
// clock lane first, then data lanes. Teardown reverses that order. Every state
// change lands on a pixel-period boundary. All outputs come straight from flops.

module smoldvi_lane_sequencer #(
  parameter int WARMUP_PERIODS   = 16,
  parameter int COOLDOWN_PERIODS = 8
) (
  input  logic       clk_x5,
  input  logic       rst_n_x5,
  input  logic       en_req,
  input  logic       hpd,
  output logic [2:0] phase,
  output logic       clk_lane_en,
  output logic       data_lane_en,
  output logic       ser_load,
  output logic [1:0] state,
  output logic       hpd_lost
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Final period-counter values that end warm-up and cool-down.
  localparam logic [7:0] WARM_LAST = 8'(WARMUP_PERIODS - 1);
  localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_PERIODS - 1);

  // The period counter saturates instead of wrapping, so it can never alias a
  // terminal count.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  logic [1:0] en_sync_r;
  logic [1:0] hpd_sync_r;
  logic       en_s;
  logic       hpd_s;
  logic       go_s;
  logic       tick_s;

  logic [2:0] phase_r;
  logic [2:0] phase_nx_s;
  state_t     state_r;
  state_t     state_nx_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nx_s;

  logic       clk_lane_en_r;
  logic       data_lane_en_r;
  logic       ser_load_r;
  logic       hpd_lost_r;
  logic       hpd_lost_nx_s;

  assign en_s   = en_sync_r[1];
  assign hpd_s  = hpd_sync_r[1];
  assign go_s   = en_s & hpd_s;
  assign tick_s = (phase_r == 3'd4);

  // Two-flop synchronisers bring the asynchronous request and hot-plug inputs into clk_x5.
  always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
    if (!rst_n_x5) begin
      en_sync_r  <= 2'b00;
      hpd_sync_r <= 2'b00;
    end else begin
      en_sync_r  <= {en_sync_r[0], en_req};
      hpd_sync_r <= {hpd_sync_r[0], hpd};
    end
  end

  // The serialiser phase counts 0..4 and wraps.
  always_comb begin
    phase_nx_s = 3'd0;
    if (phase_r == 3'd4) begin
      phase_nx_s = 3'd0;
    end else begin
      phase_nx_s = phase_r + 3'd1;
    end
  end

  // Lane state transitions. These are evaluated only on the tick cycle, so each new state starts at phase 0.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    if (tick_s) begin
      case (state_r)
        ST_OFF: begin
          if (go_s) begin
            state_nx_s = ST_WARMUP;
            cnt_nx_s   = 8'd0;
          end else begin
            state_nx_s = ST_OFF;
          end
        end
        ST_WARMUP: begin
          // A loss of go wins over warm-up completion on the same tick.
          if (!go_s) begin
            state_nx_s = ST_OFF;
            cnt_nx_s   = 8'd0;
          end else if (cnt_r == WARM_LAST) begin
            state_nx_s = ST_RUN;
            cnt_nx_s   = sat_inc(cnt_r);
          end else begin
            state_nx_s = ST_WARMUP;
            cnt_nx_s   = sat_inc(cnt_r);
          end
        end
        ST_RUN: begin
          if (!go_s) begin
            state_nx_s = ST_DRAIN;
            cnt_nx_s   = 8'd0;
          end else begin
            state_nx_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          // Cool-down always runs to completion. go is not looked at here.
          cnt_nx_s = sat_inc(cnt_r);
          if (cnt_r == COOL_LAST) begin
            state_nx_s = ST_OFF;
          end else begin
            state_nx_s = ST_DRAIN;
          end
        end
        default: begin
          state_nx_s = ST_OFF;
          cnt_nx_s   = 8'd0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
    end
  end

  // hpd_lost latches a hot-plug drop seen in RUN and is released only by withdrawing the request.
  always_comb begin
    hpd_lost_nx_s = hpd_lost_r;
    if (!en_s) begin
      hpd_lost_nx_s = 1'b0;
    end else if ((state_r == ST_RUN) && !hpd_s) begin
      hpd_lost_nx_s = 1'b1;
    end else begin
      hpd_lost_nx_s = hpd_lost_r;
    end
  end

  // Core state registers: phase, lane state and period counter.
  always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
    if (!rst_n_x5) begin
      phase_r <= 3'd0;
      state_r <= ST_OFF;
      cnt_r   <= 8'd0;
    end else begin
      phase_r <= phase_nx_s;
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Output flops are decoded from the next state, so they line up with state_r and need no extra gating.
  always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
    if (!rst_n_x5) begin
      clk_lane_en_r  <= 1'b0;
      data_lane_en_r <= 1'b0;
      ser_load_r     <= 1'b0;
      hpd_lost_r     <= 1'b0;
    end else begin
      clk_lane_en_r  <= (state_nx_s != ST_OFF);
      data_lane_en_r <= (state_nx_s == ST_RUN);
      ser_load_r     <= (state_nx_s == ST_RUN) && (phase_nx_s == 3'd0);
      hpd_lost_r     <= hpd_lost_nx_s;
    end
  end

  assign phase        = phase_r;
  assign state        = state_r;
  assign clk_lane_en  = clk_lane_en_r;
  assign data_lane_en = data_lane_en_r;
  assign ser_load     = ser_load_r;
  assign hpd_lost     = hpd_lost_r;

endmodule

// File: tb/tb_smoldvi_lane_sequencer.sv
// Directed bench for smoldvi_lane_sequencer (default parameters: 16 warm-up, 8 cool-down periods).
// Cycle n is the n-th clock period after reset release. Phase is expected to be n mod 5.
// Expected lane states per cycle are hand-derived break points.
// Each cycle, all outputs are compared as one packed vector.

module tb_smoldvi_lane_sequencer;

  logic       clk_x5   = 1'b0;
  logic       rst_n_x5 = 1'b0;
  logic       en_req   = 1'b0;
  logic       hpd      = 1'b0;
  logic [2:0] phase;
  logic       clk_lane_en;
  logic       data_lane_en;
  logic       ser_load;
  logic [1:0] state;
  logic       hpd_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk_x5 = ~clk_x5;

  smoldvi_lane_sequencer dut (
    .clk_x5       (clk_x5),
    .rst_n_x5     (rst_n_x5),
    .en_req       (en_req),
    .hpd          (hpd),
    .phase        (phase),
    .clk_lane_en  (clk_lane_en),
    .data_lane_en (data_lane_en),
    .ser_load     (ser_load),
    .state        (state),
    .hpd_lost     (hpd_lost)
  );

  // Observed vector: {phase[2:0], state[1:0], clk_lane_en, data_lane_en, ser_load, hpd_lost}
  logic [8:0] obs;
  assign obs = {phase, state, clk_lane_en, data_lane_en, ser_load, hpd_lost};

  // Expected output vector for cycle c, given the lane state and hpd_lost flag.
  function automatic logic [8:0] expv(input int c, input logic [1:0] st, input logic hl);
    logic [2:0] ph;
    ph = 3'(c % 5);
    return {ph, st, (st != 2'd0), (st == 2'd2), ((st == 2'd2) && (ph == 3'd0)), hl};
  endfunction

  task automatic reset_and_release(input logic e, input logic h);
    @(negedge clk_x5);
    rst_n_x5 = 1'b0;
    en_req   = e;
    hpd      = h;
    repeat (3) @(negedge clk_x5);
    rst_n_x5 = 1'b1;
    cyc      = 0;
  endtask

  task automatic step();
    @(negedge clk_x5);
    cyc++;
  endtask

  // Steady request from cycle 0: WARMUP from cycle 5; RUN with the first strobe at cycle 85. Ends at cycle 95.
  task automatic run_startup(input string tag);
    logic [1:0] st;
    logic [8:0] e;
    for (int c = 0; c <= 95; c++) begin
      if (c > 0) step();
      st = (c < 5) ? 2'd0 : ((c < 85) ? 2'd1 : 2'd2);
      e  = expv(c, st, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, e);
      end
    end
  endtask

  task automatic test_reset();
    logic [8:0] e;
    @(negedge clk_x5);
    rst_n_x5 = 1'b0;
    en_req   = 1'b1;
    hpd      = 1'b1;
    repeat (2) @(negedge clk_x5);
    n_checks++;
    if (obs !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected %b", obs, 9'd0);
    end
    rst_n_x5 = 1'b1;
    cyc      = 0;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) step();
      e = expv(c, 2'd0, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d: got %b expected %b", cyc, obs, e);
      end
    end
  endtask

  task automatic test_startup();
    reset_and_release(1'b1, 1'b1);
    run_startup("startup");
  endtask

  // Request dropped at cycle 96: DRAIN over cycles 100..139, then OFF from cycle 140.
  task automatic test_drain();
    logic [1:0] st;
    logic [8:0] e;
    reset_and_release(1'b1, 1'b1);
    run_startup("drain_pre");
    for (int c = 96; c <= 150; c++) begin
      step();
      if (c == 96) en_req = 1'b0;
      st = (c < 100) ? 2'd2 : ((c < 140) ? 2'd3 : 2'd0);
      e  = expv(c, st, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL drain cycle %0d: got %b expected %b", cyc, obs, e);
      end
    end
  endtask

  // hpd dropped in warm-up period 10 (cycle 55): back to OFF at cycle 60, with no data lanes at any point.
  task automatic test_hpd_warmup();
    logic [1:0] st;
    logic [8:0] e;
    reset_and_release(1'b1, 1'b1);
    for (int c = 0; c <= 75; c++) begin
      if (c > 0) step();
      if (c == 55) hpd = 1'b0;
      st = (c < 5) ? 2'd0 : ((c < 60) ? 2'd1 : 2'd0);
      e  = expv(c, st, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL hpd_warmup cycle %0d: got %b expected %b", cyc, obs, e);
      end
    end
    hpd = 1'b1;
  endtask

  // hpd dropped at cycle 96 and restored at 105. The flag is set from 99. DRAIN runs 100..139, OFF 140..144, WARMUP from 145.
  // en_req is dropped at 150: the flag clears at 153 and the block is OFF from 155.
  task automatic test_hpd_lost();
    logic [1:0] st;
    logic       hl;
    logic [8:0] e;
    reset_and_release(1'b1, 1'b1);
    run_startup("hpd_lost_pre");
    for (int c = 96; c <= 160; c++) begin
      step();
      if (c == 96)  hpd    = 1'b0;
      if (c == 105) hpd    = 1'b1;
      if (c == 150) en_req = 1'b0;
      st = (c < 100) ? 2'd2 : (c < 140) ? 2'd3 : (c < 145) ? 2'd0 : (c < 155) ? 2'd1 : 2'd0;
      hl = (c >= 99) && (c <= 152);
      e  = expv(c, st, hl);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL hpd_lost cycle %0d: got %b expected %b", cyc, obs, e);
      end
    end
  endtask

  // Reset asserted in RUN at phase 2 (cycle 97): outputs go to zero at once, then the start-up timing repeats.
  task automatic test_reset_mid_run();
    logic [8:0] e;
    reset_and_release(1'b1, 1'b1);
    run_startup("midrun_pre");
    step();
    step();
    e = expv(97, 2'd2, 1'b0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL midrun_phase2: got %b expected %b", obs, e);
    end
    rst_n_x5 = 1'b0;
    #1;
    n_checks++;
    if (obs !== 9'd0) begin
      n_fail++;
      $display("FAIL midrun_async_reset: got %b expected %b", obs, 9'd0);
    end
    reset_and_release(1'b1, 1'b1);
    run_startup("midrun_restart");
  endtask

  // Request withdrawn at 96 and re-asserted at 110, during DRAIN. DRAIN still runs to 139; OFF 140..144; WARMUP from 145.
  task automatic test_reenable_drain();
    logic [1:0] st;
    logic [8:0] e;
    reset_and_release(1'b1, 1'b1);
    run_startup("reenable_pre");
    for (int c = 96; c <= 150; c++) begin
      step();
      if (c == 96)  en_req = 1'b0;
      if (c == 110) en_req = 1'b1;
      st = (c < 100) ? 2'd2 : (c < 140) ? 2'd3 : (c < 145) ? 2'd0 : 2'd1;
      e  = expv(c, st, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reenable_drain cycle %0d: got %b expected %b", cyc, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_drain();
    test_hpd_warmup();
    test_hpd_lost();
    test_reset_mid_run();
    test_reenable_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
